// File: rtl/sram_port_arbiter_if.sv
// Purpose : groups the two requester handshakes and the SRAM macro pins of sram_port_arbiter.
// Latency : n/a (wiring only).
// Backpressure : n/a. Ports: REQn/WEn/ADDRn/WDATAn in, GNTn/RVALIDn/RDATA out, SRAM_* pins.
interface sram_port_arbiter_if #(
    parameter int BW = 32,
    parameter int AW = 10
);
    // requester 0 (instruction fetch)
    logic          REQ0;
    logic          WE0;
    logic [AW-1:0] ADDR0;
    logic [BW-1:0] WDATA0;
    logic          GNT0;
    logic          RVALID0;
    // requester 1 (load/store)
    logic          REQ1;
    logic          WE1;
    logic [AW-1:0] ADDR1;
    logic [BW-1:0] WDATA1;
    logic          GNT1;
    logic          RVALID1;
    // shared read return
    logic [BW-1:0] RDATA;
    // SRAM macro pins
    logic          SRAM_CSN;
    logic          SRAM_WEN;
    logic [AW-1:0] SRAM_A;
    logic [BW-1:0] SRAM_DI;
    logic [BW-1:0] SRAM_DOUT;

    // Environment side: requesters plus the SRAM macro.
    modport master (
        output REQ0, WE0, ADDR0, WDATA0,
        output REQ1, WE1, ADDR1, WDATA1,
        output SRAM_DOUT,
        input  GNT0, RVALID0, GNT1, RVALID1, RDATA,
        input  SRAM_CSN, SRAM_WEN, SRAM_A, SRAM_DI
    );

    // Arbiter side.
    modport slave (
        input  REQ0, WE0, ADDR0, WDATA0,
        input  REQ1, WE1, ADDR1, WDATA1,
        input  SRAM_DOUT,
        output GNT0, RVALID0, GNT1, RVALID1, RDATA,
        output SRAM_CSN, SRAM_WEN, SRAM_A, SRAM_DI
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose : two-requester arbiter/sequencer for one single-port synchronous SRAM;
//           round-robin by default, fixed priority to requester 1 when SRAM_ARB_FIXED_PRIO_EN is defined.
// Latency : grant and SRAM drive combinational; read data returns 1 cycle after grant with RVALIDn.
// Backpressure : a requester holds REQn and its payload until GNTn; the loser of a conflict waits.
// Ports   : CLK, RST (async active-high); bus (slave modport) carries both requester
//           handshakes, the shared RDATA return and the SRAM CSN/WEN/A/DI/DOUT pins.
module sram_port_arbiter #(
    parameter int BW = 32,
    parameter int AW = 10
) (
    input  logic                CLK,
    input  logic                RST,
    sram_port_arbiter_if.slave  bus
);

    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;
    logic          we_sel;
    logic [AW-1:0] a_mux;
    logic [BW-1:0] di_mux;

    // Read-return tracker: one outstanding read at most, always exactly one cycle old.
    logic          rsp_v_q;
    logic          rsp_v_d;
    logic          rsp_id_q;
    logic          rsp_id_d;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    // Most recently granted requester; reset to 1 so requester 0 wins the first conflict.
    logic          last_q;
    logic          last_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration. Grants are forced low while RST is high so nothing
    // reaches the SRAM during reset, even with requests pending.
    // ------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            gnt1 = bus.REQ1;
            gnt0 = bus.REQ0 & ~bus.REQ1;
`else
            if (bus.REQ0 && bus.REQ1) begin
                // Conflict: the requester that was not granted last wins.
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = bus.REQ0;
                gnt1 = bus.REQ1;
            end
`endif
        end
    end

    assign any_gnt = gnt0 | gnt1;

    // ------------------------------------------------------------------
    // SRAM drive: pure muxing; idle pins are parked at deterministic values.
    // ------------------------------------------------------------------
    always_comb begin
        we_sel = 1'b0;
        a_mux  = '0;
        di_mux = '0;
        if (gnt0) begin
            we_sel = bus.WE0;
            a_mux  = bus.ADDR0;
            di_mux = bus.WDATA0;
        end else if (gnt1) begin
            we_sel = bus.WE1;
            a_mux  = bus.ADDR1;
            di_mux = bus.WDATA1;
        end
    end

    assign bus.SRAM_CSN = ~any_gnt;
    assign bus.SRAM_WEN = ~(any_gnt & we_sel);
    assign bus.SRAM_A   = a_mux;
    assign bus.SRAM_DI  = di_mux;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        rsp_v_d  = any_gnt & ~we_sel;
        rsp_id_d = gnt1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_d   = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
`endif
    end

    // Async reset also drops a read granted in the cycle RST rises, so no
    // stray RVALID appears after release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_v_q  <= 1'b0;
            rsp_id_q <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            rsp_v_q  <= rsp_v_d;
            rsp_id_q <= rsp_id_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Requester-facing outputs. SRAM DOUT is registered inside the macro,
    // so RDATA is a straight pass-through.
    // ------------------------------------------------------------------
    assign bus.GNT0    = gnt0;
    assign bus.GNT1    = gnt1;
    assign bus.RVALID0 = rsp_v_q & ~rsp_id_q;
    assign bus.RVALID1 = rsp_v_q &  rsp_id_q;
    assign bus.RDATA   = bus.SRAM_DOUT;

endmodule
